// File: rtl/reg_file_if.sv
// Register-file access bus: two read ports, one write port and the write counter.
// The requester (datapath) uses the master modport and the register file uses the slave modport.
interface reg_file_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
);
    logic [ADDR_W-1:0] readReg1;
    logic [ADDR_W-1:0] readReg2;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              regWrite;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic [DATA_W-1:0] wrCount;

    modport master (
        output readReg1, readReg2, writeReg, writeData, regWrite,
        input  readData1, readData2, wrCount
    );

    modport slave (
        input  readReg1, readReg2, writeReg, writeData, regWrite,
        output readData1, readData2, wrCount
    );
endinterface

// File: rtl/reg_file.sv
// 8 x 16-bit register file: r0 is hardwired to zero and r7 resets to SP_INIT; it counts committed writes.
// Optional macro REG_FILE_BYPASS_EN: a same-cycle write is forwarded (write-through) to any matching read port.
module reg_file #(
    parameter logic [15:0] SP_INIT = 16'h00FF
) (
    input  logic       clk,
    input  logic       rst_n,
    reg_file_if.slave  bus
);
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned SP_IDX   = 7;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] wr_cnt_q;
    logic [DATA_W-1:0] wr_cnt_d;
    logic              wr_en_c;
    logic [DATA_W-1:0] rd1_c;
    logic [DATA_W-1:0] rd2_c;

    // A write commits only outside reset and never targets r0.
    assign wr_en_c = rst_n && bus.regWrite && (bus.writeReg != '0);

    always_comb begin
        regs_d   = regs_q;
        wr_cnt_d = wr_cnt_q;
        if (wr_en_c) begin
            regs_d[bus.writeReg] = bus.writeData;
            wr_cnt_d             = wr_cnt_q + DATA_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (ADDR_W'(i) == ADDR_W'(SP_IDX)) ? SP_INIT : '0;
            end
            wr_cnt_q <= '0;
        end else begin
            regs_q   <= regs_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Read ports are combinational; r0 is forced to zero regardless of storage.
    always_comb begin
        rd1_c = regs_q[bus.readReg1];
        rd2_c = regs_q[bus.readReg2];
`ifdef REG_FILE_BYPASS_EN
        if (wr_en_c && (bus.readReg1 == bus.writeReg)) rd1_c = bus.writeData;
        if (wr_en_c && (bus.readReg2 == bus.writeReg)) rd2_c = bus.writeData;
`endif
        if (bus.readReg1 == '0) rd1_c = '0;
        if (bus.readReg2 == '0) rd2_c = '0;
    end

    assign bus.readData1 = rd1_c;
    assign bus.readData2 = rd2_c;
    assign bus.wrCount   = wr_cnt_q;

endmodule

// File: tb/tb_reg_file.sv
// Randomized scoreboard bench for reg_file: a stimulus process queues expected read/count values
// from an array-based model, and a monitor compares them against the DUT on each falling edge.
module tb_reg_file;
    typedef struct packed {
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    reg_file_if bus ();

    reg_file #(.SP_INIT(16'h00FF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] model [8];
    int          model_cnt;
    exp_t        exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [15:0] model_read(input logic [2:0] addr, input logic rst,
                                               input logic we, input logic [2:0] wa,
                                               input logic [15:0] wd);
        if (addr == 3'd0) return 16'h0000;
`ifdef REG_FILE_BYPASS_EN
        if (rst && we && wa != 3'd0 && addr == wa) return wd;
`endif
        return model[addr];
    endfunction

    task automatic model_edge(input logic rst, input logic we, input logic [2:0] wa,
                              input logic [15:0] wd);
        if (!rst) begin
            for (int i = 0; i < 8; i++) model[i] = 16'h0000;
            model[7]  = 16'h00FF;
            model_cnt = 0;
        end else if (we && wa != 3'd0) begin
            model[wa] = wd;
            model_cnt = (model_cnt + 1) % 65536;
        end
    endtask

    // One clock of stimulus: drive, queue the expected pre-edge outputs, then apply the edge to the model.
    task automatic step(input logic rst, input logic we, input logic [2:0] wa,
                        input logic [15:0] wd, input logic [2:0] r1, input logic [2:0] r2);
        exp_t e;
        rst_n         = rst;
        bus.regWrite  = we;
        bus.writeReg  = wa;
        bus.writeData = wd;
        bus.readReg1  = r1;
        bus.readReg2  = r2;
        e.rd1 = model_read(r1, rst, we, wa, wd);
        e.rd2 = model_read(r2, rst, we, wa, wd);
        e.cnt = 16'(model_cnt);
        exp_q.push_back(e);
        @(posedge clk);
        model_edge(rst, we, wa, wd);
        #1;
    endtask

    task automatic rand_step(input bool_rst_allowed);
        logic rst;
        rst = !(bool_rst_allowed && ($urandom_range(0, 63) == 0));
        step(rst, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (bus.readData1 !== e.rd1) begin
                    n_bad++;
                    $display("FAIL rd1 t=%0t addr=%0d got=%h want=%h", $time, bus.readReg1, bus.readData1, e.rd1);
                end
                n_cmp++;
                if (bus.readData2 !== e.rd2) begin
                    n_bad++;
                    $display("FAIL rd2 t=%0t addr=%0d got=%h want=%h", $time, bus.readReg2, bus.readData2, e.rd2);
                end
                n_cmp++;
                if (bus.wrCount !== e.cnt) begin
                    n_bad++;
                    $display("FAIL wrcnt t=%0t got=%h want=%h", $time, bus.wrCount, e.cnt);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        model_cnt     = 0;
        rst_n         = 1'b0;
        bus.regWrite  = 1'b0;
        bus.writeReg  = 3'd0;
        bus.writeData = 16'h0000;
        bus.readReg1  = 3'd0;
        bus.readReg2  = 3'd0;
        // Initial reset edge; contents are unknown before it so nothing is queued.
        @(posedge clk);
        model_edge(1'b0, 1'b0, 3'd0, 16'h0);
        #1;

        // Reset values on every register.
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd1, 3'd2);
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd3, 3'd4);
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd5, 3'd6);
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd7, 3'd0);

        // Write then dual-port read of the same register.
        step(1'b1, 1'b1, 3'd3, 16'hBEEF, 3'd1, 3'd2);
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd3, 3'd3);

        // r0 writes are discarded and not counted.
        step(1'b1, 1'b1, 3'd0, 16'h1234, 3'd0, 3'd0);
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd3);

        // Same-cycle read of the write target (old value, or forwarded with bypass).
        step(1'b1, 1'b1, 3'd5, 16'h0011, 3'd1, 3'd2);
        step(1'b1, 1'b1, 3'd5, 16'h0022, 3'd5, 3'd5);
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd5, 3'd7);

        // Reset wins over a simultaneous write; reads still show pre-reset contents.
        step(1'b1, 1'b1, 3'd2, 16'h5555, 3'd2, 3'd5);
        step(1'b0, 1'b1, 3'd2, 16'hFFFF, 3'd2, 3'd5);
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd2, 3'd7);

        // Randomized traffic including occasional resets.
        for (int i = 0; i < 3000; i++) rand_step(1'b1);

        // Counter wrap: 65536 committed writes to r1 after reset.
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd1, 3'd7);
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, 1'b1, 3'd1, 16'($urandom), 3'($urandom_range(0, 7)), 3'd1);
        end
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd1, 3'd1);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter SP_INIT, default 16'h00FF, giving the reset value of register 7 (stack pointer).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port readReg1, input, 3 bits: read port 1 address.
REQ-005 The block SHALL have port readReg2, input, 3 bits: read port 2 address.
REQ-006 The block SHALL have port writeReg, input, 3 bits: write address.
REQ-007 The block SHALL have port writeData, input, 16 bits: write data, normally the ALU out or memory data.
REQ-008 The block SHALL have port regWrite, input, 1 bit: write enable.
REQ-009 The block SHALL have port readData1, output, 16 bits: register value at readReg1, driving ALU input a.
REQ-010 The block SHALL have port readData2, output, 16 bits: register value at readReg2, driving ALU input b / store data.
REQ-011 The block SHALL have port wrCount, output, 16 bits: count of committed writes (debug/performance).

Function
REQ-012 The block SHALL hold 8 registers r0..r7, each 16 bits.
REQ-013 readData1/readData2 SHALL be combinational from the addresses and register contents; zero-cycle read latency.
REQ-014 On a rising clk with rst_n=1 and regWrite=1 and writeReg!=0, the block SHALL store writeData into r[writeReg]; the new value SHALL be visible on the read ports after that edge.
REQ-015 r0 SHALL always read 16'h0000; writes to r0 SHALL be discarded and SHALL NOT be counted.
REQ-016 With regWrite=0, no register SHALL change.
REQ-017 Both read ports SHALL be able to address the same register simultaneously and both SHALL return the same value.
REQ-018 A read of the register being written in the same cycle SHALL return the old value (write-first behaviour only when REG_FILE_BYPASS_EN is defined; see REQ-024).
REQ-019 wrCount SHALL increment by 1 on every committed write (REQ-014) and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-020 Register contents SHALL be unaffected by X-free address changes between edges; there is no read state.

Reset
REQ-021 When rst_n=0 at a rising clk, r1..r6 SHALL become 16'h0000, r7 SHALL become SP_INIT, and wrCount SHALL become 0.
REQ-022 Reset SHALL take priority over a simultaneous write; that write SHALL be lost and SHALL NOT be counted.
REQ-023 Reads during reset SHALL keep reflecting current contents combinationally; contents change only at the reset edge.

Configuration
REQ-024 With macro REG_FILE_BYPASS_EN defined, when regWrite=1, writeReg!=0 and a read address equals writeReg, that read port SHALL return writeData in the same cycle (write-through); r0 reads SHALL still return 0 and rst_n=0 SHALL suppress the bypass.
REQ-025 With REG_FILE_BYPASS_EN undefined, read ports SHALL return stored contents only (REQ-018 old-value behaviour).

Verification
REQ-026 Reset: rst_n=0 for one edge -> readData for r1..r6 = 16'h0000, r7 = 16'h00FF, wrCount = 0.
REQ-027 Write/read: regWrite=1, writeReg=3, writeData=16'hBEEF, one edge; readReg1=3, readReg2=3 -> both read 16'hBEEF, wrCount = 1.
REQ-028 r0 guard: regWrite=1, writeReg=0, writeData=16'h1234 -> readData1 at r0 = 16'h0000, wrCount unchanged.
REQ-029 Same-cycle read of write target: r5=16'h0011, write 16'h0022 to r5 while readReg1=5 -> before the edge readData1 = 16'h0011 without the macro and 16'h0022 with REG_FILE_BYPASS_EN; after the edge 16'h0022 in both builds.
REQ-030 Reset vs write: rst_n=0 with regWrite=1, writeReg=2, writeData=16'hFFFF -> r2 = 0, wrCount = 0.
REQ-031 Wrap: 65536 committed writes to r1 after reset -> wrCount = 16'h0000, and the last value written to r1 is readable.
